// File: rtl/execute_multdiv_if.sv
// rtl/execute_multdiv_if.sv - execute-stage request/response bundle for the multiply/divide unit
interface execute_multdiv_if;
    logic        start_valid;
    logic [4:0]  alu_opcode;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        flush;
    logic        stall;
    logic [31:0] result;
    logic        exception;
    logic        result_ready;

    modport master (
        output start_valid, alu_opcode, operand_a, operand_b, flush,
        input  stall, result, exception, result_ready
    );

    modport slave (
        input  start_valid, alu_opcode, operand_a, operand_b, flush,
        output stall, result, exception, result_ready
    );
endinterface

// File: rtl/execute_multdiv.sv
// rtl/execute_multdiv.sv - iterative signed MUL/DIV unit that stalls the pipeline while busy
module execute_multdiv #(
    parameter int ITERATIONS = 32
) (
    input  logic              clock,
    input  logic              reset,
    execute_multdiv_if.slave  bus
);
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;
    localparam logic [4:0] LAST   = 5'(ITERATIONS - 1);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  count;
    logic [31:0] mag;
    logic [63:0] acc;
    logic        neg;
    logic        div_zero;
    logic [31:0] result_q;
    logic        exception_q;

    logic        is_md;
    logic        accept;
    logic [31:0] abs_a, abs_b;

    // Multiply: acc = {partial sum, remaining multiplier bits}, shifted right each step.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] mul_signed;
    logic        mul_ovf;

    // Divide: acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ok;
    logic [31:0] div_rem;
    logic [63:0] div_next;
    logic [31:0] quo;
    logic [31:0] div_signed;
    logic        div_ovf;

    assign is_md  = (bus.alu_opcode == OP_MUL) || (bus.alu_opcode == OP_DIV);
    assign accept = bus.start_valid && ((state == IDLE) || (state == DONE))
                    && !reset && !bus.flush && is_md;

    assign abs_a = bus.operand_a[31] ? -bus.operand_a : bus.operand_a;
    assign abs_b = bus.operand_b[31] ? -bus.operand_b : bus.operand_b;

    assign mul_sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag} : 33'd0);
    assign mul_next   = {mul_sum, acc[31:1]};
    assign mul_signed = neg ? -mul_next : mul_next;
    assign mul_ovf    = !((&mul_signed[63:31]) || !(|mul_signed[63:31]));

    assign div_shift  = {acc[63:32], acc[31]};
    assign div_diff   = div_shift - {1'b0, mag};
    assign div_ok     = !div_diff[32];
    assign div_rem    = div_ok ? div_diff[31:0] : div_shift[31:0];
    assign div_next   = {div_rem, acc[30:0], div_ok};
    assign quo        = div_next[31:0];
    assign div_signed = neg ? -quo : quo;
    // A positive quotient of 2^31 (only -2^31 / -1) does not fit; a negative one does.
    assign div_ovf    = quo[31] && (!neg || (|quo[30:0]));

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = (bus.alu_opcode == OP_MUL) ? MULT : DIV;
                else
                    state_next = IDLE;
            end
            MULT, DIV: begin
                if (count == LAST)
                    state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
        if (bus.flush)
            state_next = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            count       <= 5'd0;
            mag         <= 32'd0;
            acc         <= 64'd0;
            neg         <= 1'b0;
            div_zero    <= 1'b0;
            result_q    <= 32'd0;
            exception_q <= 1'b0;
        end else begin
            state <= state_next;
            if (bus.flush) begin
                count <= 5'd0;
            end else if (accept) begin
                count    <= 5'd0;
                neg      <= bus.operand_a[31] ^ bus.operand_b[31];
                div_zero <= (bus.operand_b == 32'd0);
                if (bus.alu_opcode == OP_MUL) begin
                    mag <= abs_a;
                    acc <= {32'd0, abs_b};
                end else begin
                    mag <= abs_b;
                    acc <= {32'd0, abs_a};
                end
            end else if (state == MULT) begin
                acc   <= mul_next;
                count <= (count == LAST) ? 5'd0 : count + 5'd1;
                if (count == LAST) begin
                    result_q    <= mul_signed[31:0];
                    exception_q <= mul_ovf;
                end
            end else if (state == DIV) begin
                acc   <= div_next;
                count <= (count == LAST) ? 5'd0 : count + 5'd1;
                if (count == LAST) begin
                    result_q    <= div_zero ? 32'd0 : div_signed;
                    exception_q <= div_zero || div_ovf;
                end
            end
        end
    end

    assign bus.stall        = !reset && (accept || (state == MULT) || (state == DIV));
    assign bus.result       = result_q;
    assign bus.exception    = exception_q;
    assign bus.result_ready = (state == DONE);
endmodule

// File: tb/tb_execute_multdiv.sv
// tb/tb_execute_multdiv.sv - randomized self-checking bench for execute_multdiv
module tb_execute_multdiv;
    localparam logic [4:0] OP_MUL = 5'b00110;
    localparam logic [4:0] OP_DIV = 5'b00111;

    logic clock = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    execute_multdiv_if bus ();

    execute_multdiv #(.ITERATIONS(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Reference: signed arithmetic on wide integers, returns {exception, result}.
    function automatic logic [32:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb, q;
        longint p;
        logic [63:0] pb;
        sa = a;
        sb = b;
        if (op == OP_MUL) begin
            p  = longint'(sa) * longint'(sb);
            pb = p;
            return {(p > 64'sd2147483647) || (p < -64'sd2147483648), pb[31:0]};
        end
        if (b == 32'd0)
            return {1'b1, 32'd0};
        if (a == 32'h80000000 && b == 32'hFFFFFFFF)
            return {1'b1, 32'h80000000};
        q = sa / sb;
        return {1'b0, q};
    endfunction

    // Issues an op in the current cycle and follows it to its result; optionally
    // re-issues a stray MUL start at cycle ignore_at while the unit is busy.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int ignore_at);
        logic [32:0] exp;
        int lat, stalls;
        exp    = model(op, a, b);
        lat    = -1;
        stalls = 0;
        bus.start_valid = 1'b1;
        bus.alu_opcode  = op;
        bus.operand_a   = a;
        bus.operand_b   = b;
        #1;
        for (int c = 0; c < 60; c++) begin
            if (c > 0) begin
                bus.start_valid = (c == ignore_at);
                bus.alu_opcode  = OP_MUL;
                bus.operand_a   = $urandom;
                bus.operand_b   = $urandom;
                #1;
                if (bus.result_ready) begin
                    lat = c;
                    break;
                end
            end
            if (bus.stall) stalls++;
            tick();
        end
        bus.start_valid = 1'b0;
        check("latency", 64'(lat), 64'(33));
        check("stall_cycles", 64'(stalls), 64'(33));
        check("stall_in_done", 64'(bus.stall), 64'(0));
        check("result", 64'(bus.result), 64'(exp[31:0]));
        check("exception", 64'(bus.exception), 64'(exp[32]));
    endtask

    logic [31:0] edges [6] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'd2};

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return edges[$urandom_range(0, 5)];
            1: return 32'(int'($urandom_range(0, 40)) - 20);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] prev;
        int pulses;

        reset           = 1'b1;
        bus.start_valid = 1'b1;
        bus.alu_opcode  = OP_MUL;
        bus.operand_a   = 32'd3;
        bus.operand_b   = 32'd4;
        bus.flush       = 1'b0;
        tick();
        tick();
        check("rst_stall", 64'(bus.stall), 64'(0));
        check("rst_result", 64'(bus.result), 64'(0));
        check("rst_exception", 64'(bus.exception), 64'(0));
        check("rst_ready", 64'(bus.result_ready), 64'(0));
        reset           = 1'b0;
        bus.start_valid = 1'b0;
        tick();

        run_op(OP_MUL, 32'd7, 32'hFFFFFFFA, 0);
        tick();
        run_op(OP_MUL, 32'h00010000, 32'h00010000, 0);
        run_op(OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);      // accepted in DONE
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 0);
        tick();
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0);
        tick();
        run_op(OP_DIV, 32'd5, 32'd0, 0);
        tick();
        run_op(OP_MUL, 32'd123, 32'hFFFFFF00, 5);           // stray start at cycle 5

        // Unsupported opcode: no stall, no side effect.
        tick();
        prev = bus.result;
        bus.start_valid = 1'b1;
        bus.alu_opcode  = 5'b00000;
        bus.operand_a   = $urandom;
        bus.operand_b   = $urandom;
        #1;
        check("bad_op_stall", 64'(bus.stall), 64'(0));
        tick();
        bus.start_valid = 1'b0;
        #1;
        check("bad_op_stall_after", 64'(bus.stall), 64'(0));
        check("bad_op_result", 64'(bus.result), 64'(prev));

        // Flush together with start in IDLE: nothing accepted.
        bus.start_valid = 1'b1;
        bus.alu_opcode  = OP_DIV;
        bus.flush       = 1'b1;
        #1;
        check("flush_start_stall", 64'(bus.stall), 64'(0));
        tick();
        bus.start_valid = 1'b0;
        bus.flush       = 1'b0;
        #1;
        check("flush_start_idle", 64'(bus.stall), 64'(0));

        // Flush at cycle 10 of a MUL, then DIV 100/10 accepted at cycle 12.
        tick();
        prev   = bus.result;
        pulses = 0;
        bus.start_valid = 1'b1;
        bus.alu_opcode  = OP_MUL;
        bus.operand_a   = 32'd9;
        bus.operand_b   = 32'd9;
        tick();
        bus.start_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            bus.flush = (c == 10);
            #1;
            if (bus.result_ready) pulses++;
            if (c == 11) check("flush_stall", 64'(bus.stall), 64'(0));
            if (c < 11) tick();
        end
        check("flush_no_ready", 64'(pulses), 64'(0));
        check("flush_result_kept", 64'(bus.result), 64'(prev));
        tick();
        run_op(OP_DIV, 32'd100, 32'd10, 0);

        // Randomized operations, sometimes back-to-back from DONE.
        for (int i = 0; i < 30; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            repeat (gap) tick();
            run_op($urandom_range(0, 1) ? OP_MUL : OP_DIV, pick(), pick(), 0);
        end

        // Reset at cycle 20 of an operation.
        tick();
        run_op(OP_MUL, 32'h00012345, 32'h00000777, 0);
        tick();
        bus.start_valid = 1'b1;
        bus.alu_opcode  = OP_MUL;
        bus.operand_a   = 32'd5;
        bus.operand_b   = 32'd6;
        tick();
        bus.start_valid = 1'b0;
        repeat (19) tick();
        reset = 1'b1;
        #1;
        check("reset_stall_drop", 64'(bus.stall), 64'(0));
        tick();
        reset = 1'b0;
        #1;
        check("reset_result", 64'(bus.result), 64'(0));
        check("reset_exception", 64'(bus.exception), 64'(0));
        check("reset_ready", 64'(bus.result_ready), 64'(0));
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.result_ready || bus.stall) pulses++;
            tick();
        end
        check("reset_no_ready", 64'(pulses), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
